multi_phase_enable_generator: RTL and testbench



---
 rtl/enable_gen_pkg.sv | 26 ++
 rtl/enable_generator_channel.sv | 68 ++++++
 rtl/multi_phase_enable_generator.sv | 79 +++++++
 tb/tb_multi_phase_enable_generator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/enable_gen_pkg.sv
// Shared definitions for the multi-phase enable generator: channel modes and
// the wrapped clear-point calculation used by clock-mode channels.
package enable_gen_pkg;

  localparam logic MODE_PULSE = 1'b0;
  localparam logic MODE_CLOCK = 1'b1;

  // Widest counter the clear-point helper supports; callers zero-extend into it.
  localparam int unsigned MaxCounterWidth = 64;

  typedef logic [MaxCounterWidth-1:0] cnt_max_t;

  // Falling-edge point of a clock-mode channel: phase + half, wrapped into the
  // period. One extra bit keeps the sum exact before the wrap test.
  function automatic cnt_max_t clock_clear_point(input cnt_max_t phase,
                                                 input cnt_max_t half,
                                                 input cnt_max_t period);
    logic [MaxCounterWidth:0] sum;
    sum = {1'b0, phase} + {1'b0, half};
    if (sum >= {1'b0, period}) begin
      sum = sum - {1'b0, period};
    end
    return sum[MaxCounterWidth-1:0];
  endfunction

endpackage

// File: rtl/enable_generator_channel.sv
// One enable output: shadowed phase, pulse/clock mode decode and output flop.
module enable_generator_channel
  import enable_gen_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run_i,
  input  logic                     load_i,
  input  logic [COUNTER_WIDTH-1:0] counter_i,
  input  logic [COUNTER_WIDTH-1:0] active_period_i,
  input  logic [COUNTER_WIDTH-1:0] phase_i,
  input  logic                     mode_i,
  input  logic                     channel_enable_i,
  output logic                     enable_o
);

  logic [COUNTER_WIDTH-1:0] phase_d, phase_q;
  logic                     enable_d, enable_q;
  logic [COUNTER_WIDTH-1:0] half;
  logic [COUNTER_WIDTH-1:0] clr;
  logic                     hit_set;
  logic                     hit_clr;

  assign half = active_period_i >> 1;
  assign clr  = COUNTER_WIDTH'(clock_clear_point(MaxCounterWidth'(phase_q),
                                                 MaxCounterWidth'(half),
                                                 MaxCounterWidth'(active_period_i)));

  // Next phase shadow and next output level from the current counter value.
  always_comb begin
    phase_d  = phase_q;
    enable_d = enable_q;
    hit_set  = (counter_i == phase_q);
    hit_clr  = (counter_i == clr);

    if (load_i) begin
      phase_d = phase_i;
    end

    // A phase at or beyond the period never equals the counter, so such a
    // channel simply stays low without a dedicated check.
    if (!run_i || !channel_enable_i) begin
      enable_d = 1'b0;
    end else if (mode_i == MODE_PULSE || half == '0) begin
      enable_d = hit_set;
    end else if (hit_set) begin
      enable_d = 1'b1;
    end else if (hit_clr) begin
      enable_d = 1'b0;
    end
  end

  // Phase shadow and output register, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      phase_q  <= '0;
      enable_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      enable_q <= enable_d;
    end
  end

  assign enable_o = enable_q;

endmodule

// File: rtl/multi_phase_enable_generator.sv
// Shared period counter with shadowed period, wrap strobe and N phase-offset
// enable channels. Supports N_CHANNELS 1..16 and COUNTER_WIDTH up to 64.
module multi_phase_enable_generator
  import enable_gen_pkg::*;
#(
  parameter int unsigned N_CHANNELS    = 4,
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                gen_enable_in,
  input  logic [COUNTER_WIDTH-1:0]            period,
  input  logic [N_CHANNELS*COUNTER_WIDTH-1:0] phase,
  input  logic [N_CHANNELS-1:0]               mode,
  input  logic [N_CHANNELS-1:0]               channel_enable,
  output logic [N_CHANNELS-1:0]               enable_out,
  output logic [COUNTER_WIDTH-1:0]            counter_out,
  output logic                                wrap_out
);

  logic [COUNTER_WIDTH-1:0] counter_d, counter_q;
  logic [COUNTER_WIDTH-1:0] active_period_d, active_period_q;
  logic                     wrap_d, wrap_q;
  logic                     run;
  logic                     at_end;
  logic                     load;

  // Shadows follow the inputs while idle; while running they only move at the
  // last count so a new period/phase set always starts from counter 0.
  always_comb begin
    run             = gen_enable_in && (active_period_q != '0);
    at_end          = run && (counter_q == active_period_q - COUNTER_WIDTH'(1));
    load            = !gen_enable_in || (active_period_q == '0) || at_end;
    counter_d       = '0;
    active_period_d = active_period_q;
    wrap_d          = at_end;

    if (run && !at_end) begin
      counter_d = counter_q + COUNTER_WIDTH'(1);
    end
    if (load) begin
      active_period_d = period;
    end
  end

  // Shared counter, period shadow and wrap strobe registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      counter_q       <= '0;
      active_period_q <= '0;
      wrap_q          <= 1'b0;
    end else begin
      counter_q       <= counter_d;
      active_period_q <= active_period_d;
      wrap_q          <= wrap_d;
    end
  end

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_channel
    enable_generator_channel #(
      .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_channel (
      .clock            (clock),
      .reset            (reset),
      .run_i            (run),
      .load_i           (load),
      .counter_i        (counter_q),
      .active_period_i  (active_period_q),
      .phase_i          (phase[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .mode_i           (mode[i]),
      .channel_enable_i (channel_enable[i]),
      .enable_o         (enable_out[i])
    );
  end

  assign counter_out = counter_q;
  assign wrap_out    = wrap_q;

endmodule

// File: tb/tb_multi_phase_enable_generator.sv
// Scoreboard bench: stimulus queues hand-derived per-cycle expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_multi_phase_enable_generator;

  localparam int unsigned NCh = 4;
  localparam int unsigned Cw  = 32;

  logic                clock = 1'b0;
  logic                reset;
  logic                gen_enable_in;
  logic [Cw-1:0]       period;
  logic [NCh*Cw-1:0]   phase;
  logic [NCh-1:0]      mode;
  logic [NCh-1:0]      channel_enable;
  logic [NCh-1:0]      enable_out;
  logic [Cw-1:0]       counter_out;
  logic                wrap_out;

  multi_phase_enable_generator #(
    .N_CHANNELS    (NCh),
    .COUNTER_WIDTH (Cw)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .gen_enable_in  (gen_enable_in),
    .period         (period),
    .phase          (phase),
    .mode           (mode),
    .channel_enable (channel_enable),
    .enable_out     (enable_out),
    .counter_out    (counter_out),
    .wrap_out       (wrap_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned    cyc;
    logic [NCh-1:0] en;
    logic [Cw-1:0]  cnt;
    logic           wrap;
    string          name;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  // Posedge count; state seen at negedge N is the result of posedge N.
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: outputs are presented every cycle; check whatever is due.
  always @(negedge clock) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (e.cyc != cyc || enable_out !== e.en || counter_out !== e.cnt || wrap_out !== e.wrap) begin
        n_err++;
        $display("FAIL %s @cyc %0d (due %0d): got en=%b cnt=%0d wrap=%b, want en=%b cnt=%0d wrap=%b",
                 e.name, cyc, e.cyc, enable_out, counter_out, wrap_out, e.en, e.cnt, e.wrap);
      end
    end
  end

  task automatic push(input int unsigned c, input logic [NCh-1:0] en, input int unsigned cnt,
                      input logic wr, input string nm);
    exp_t e;
    e.cyc  = c;
    e.en   = en;
    e.cnt  = cnt;
    e.wrap = wr;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Pulse pattern for phases {ch3=9, ch2=5, ch1=3, ch0=0} given the previous counter.
  function automatic logic [NCh-1:0] pulse4(input int p);
    return {p == 9, p == 5, p == 3, p == 0};
  endfunction

  localparam logic [NCh*Cw-1:0] PhPulse = {32'd9, 32'd5, 32'd3, 32'd0};

  initial begin
    int unsigned b;
    int          p;
    int          m;
    logic [NCh-1:0] e;

    reset = 1'b0; gen_enable_in = 1'b0; period = '0; phase = '0; mode = '0;
    channel_enable = '0;
    step(); step();
    gen_enable_in = 1'b1; period = 32'd10; channel_enable = 4'hF;
    push(cyc + 1, 4'b0, 0, 1'b0, "reset_hold");
    step();

    // Pulse mode, period 10, phases {0,3,5,9}.
    reset = 1'b1; gen_enable_in = 1'b0; period = 32'd10; phase = PhPulse; mode = 4'b0000;
    channel_enable = 4'hF;
    b = cyc + 1;
    for (int k = 0; k < 25; k++) begin
      p = (k + 9) % 10;
      push(b + k, (k > 0) ? pulse4(p) : 4'b0, k % 10, k > 0 && p == 9, "pulse_p10");
    end
    step(); gen_enable_in = 1'b1;
    repeat (24) step();

    // Clock mode ch0 phase 0, ch1 phase 8; ch0 gated off briefly mid-high.
    gen_enable_in = 1'b0; phase = {32'd0, 32'd0, 32'd8, 32'd0}; mode = 4'b0011;
    channel_enable = 4'b0011;
    b = cyc + 1;
    for (int k = 0; k < 25; k++) begin
      p = (k + 9) % 10;
      e = 4'b0;
      e[0] = (k == 1 || k == 2) || (k >= 11 && p < 5);
      e[1] = (k >= 9) && (p >= 8 || p <= 2);
      push(b + k, e, k % 10, k > 0 && p == 9, "clock_p10");
    end
    step(); gen_enable_in = 1'b1;
    step(); step();
    channel_enable = 4'b0010;
    step(); step();
    channel_enable = 4'b0011;
    repeat (20) step();

    // Period 10 -> 6 written at counter 4; takes effect after counter 9.
    gen_enable_in = 1'b0; period = 32'd10; phase = PhPulse; mode = 4'b0000;
    channel_enable = 4'hF;
    b = cyc + 1;
    for (int k = 0; k < 31; k++) begin
      if (k <= 10) begin
        p = (k + 9) % 10;
        push(b + k, (k > 0) ? pulse4(p) : 4'b0, k % 10, k > 0 && p == 9, "period_chg_old");
      end else begin
        m = k - 10;
        p = (m + 5) % 6;
        push(b + k, pulse4(p), m % 6, p == 5, "period_chg_new");
      end
    end
    step(); gen_enable_in = 1'b1;
    repeat (4) step();
    period = 32'd6;
    repeat (26) step();

    // Period 1: ch0 phase 0 always high, ch1 phase 5 never.
    gen_enable_in = 1'b0; period = 32'd1; phase = {32'd0, 32'd0, 32'd5, 32'd0};
    channel_enable = 4'b0011;
    b = cyc + 1;
    for (int k = 0; k < 9; k++) begin
      push(b + k, (k > 0) ? 4'b0001 : 4'b0, 0, k > 0, "period1");
    end
    step(); gen_enable_in = 1'b1;
    repeat (8) step();

    // Run stopped at counter 7, then restarted.
    gen_enable_in = 1'b0; period = 32'd10; phase = PhPulse; channel_enable = 4'hF;
    b = cyc + 1;
    for (int k = 0; k < 25; k++) begin
      if (k <= 7) begin
        p = (k + 9) % 10;
        push(b + k, (k > 0) ? pulse4(p) : 4'b0, k % 10, k > 0 && p == 9, "stop_before");
      end else if (k <= 9) begin
        push(b + k, 4'b0, 0, 1'b0, "stop_cleared");
      end else begin
        m = k - 9;
        p = (m + 9) % 10;
        push(b + k, pulse4(p), m % 10, p == 9, "restart");
      end
    end
    step(); gen_enable_in = 1'b1;
    repeat (7) step();
    gen_enable_in = 1'b0;
    repeat (2) step();
    gen_enable_in = 1'b1;
    repeat (15) step();

    // Reset at counter 5 with a period change to 4 pending.
    gen_enable_in = 1'b0; period = 32'd10; phase = PhPulse; channel_enable = 4'hF;
    b = cyc + 1;
    for (int k = 0; k < 21; k++) begin
      if (k <= 5) begin
        p = (k + 9) % 10;
        push(b + k, (k > 0) ? pulse4(p) : 4'b0, k % 10, 1'b0, "rst_before");
      end else if (k <= 8) begin
        push(b + k, 4'b0, 0, 1'b0, "rst_cleared");
      end else begin
        m = k - 8;
        p = (m + 3) % 4;
        push(b + k, pulse4(p), m % 4, p == 3, "rst_new_period");
      end
    end
    step(); gen_enable_in = 1'b1;
    repeat (5) step();
    period = 32'd4; reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    repeat (13) step();

    repeat (2) step();
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d expectations left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
